// File: rtl/red_pitaya_sort_pulse_if.sv
// System bus between the register master and the sort pulse responder.
// One request per cycle on sys_wen/sys_ren; the responder never stalls and
// returns sys_ack (with sys_rdata for reads) exactly one cycle later.
interface red_pitaya_sort_pulse_if;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic [3:0]  sys_sel;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   modport master (
      output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
      input  sys_rdata, sys_err, sys_ack
   );

   modport slave (
      input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
      output sys_rdata, sys_err, sys_ack
   );
endinterface

// File: rtl/red_pitaya_sort_pulse.sv
// FADS sort pulse generator: turns accepted sort_trig events into one delayed,
// fixed-width, fixed-amplitude DAC pulse followed by a dead time.
module red_pitaya_sort_pulse #(
   parameter int DWT = 14,
   parameter int CW  = 32
) (
   input  logic                  adc_clk_i,
   input  logic                  adc_rstn_i,
   input  logic                  sort_trig_i,
   output logic signed [DWT-1:0] dac_o,
   output logic                  pulse_active_o,
   red_pitaya_sort_pulse_if.slave sys
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      PULSE = 2'd2,
      DEAD  = 2'd3
   } state_t;

   localparam logic [CW-1:0]  ONE       = CW'(1);
   localparam logic [CW-1:0]  CNT_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0]  WIDTH_RST = CW'(1250);
   localparam logic [DWT-1:0] AMP_RST   = {1'b0, {(DWT-1){1'b1}}};

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  delay_q, delay_d, width_q, width_d, dead_q, dead_d;
   logic [CW-1:0]  width_s_q, width_s_d, dead_s_q, dead_s_d;
   logic [CW-1:0]  evt_cnt_q, evt_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [DWT-1:0] amp_q, amp_d, amp_s_q, amp_s_d;
   logic [DWT-1:0] dac_q, dac_d;
   logic           en_q, en_d, trig_q, trig_d, active_q, active_d;
   logic           ack_q, ack_d;
   logic [31:0]    rdata_q, rdata_d;

   logic [19:0]    addr;
   logic           wr_ctrl, sw_trig, clr_cnt, en_eff, trig_edge, evt;
   logic           evt_inc, drop_inc;
   logic           unused_bus;

   assign unused_bus = ^{sys.sys_sel, sys.sys_addr[31:20], sys.sys_wdata};

   // A ctrl write acts at the edge that samples it, so enable/sw_trig/clr
   // all take effect together with that write.
   always_comb begin
      addr      = sys.sys_addr[19:0];
      wr_ctrl   = sys.sys_wen && (addr == 20'h00);
      sw_trig   = wr_ctrl && sys.sys_wdata[1];
      clr_cnt   = wr_ctrl && sys.sys_wdata[2];
      en_eff    = wr_ctrl ? sys.sys_wdata[0] : en_q;
      trig_d    = sort_trig_i;
      trig_edge = sort_trig_i & ~trig_q;
      evt       = en_eff & (trig_edge | sw_trig);

      en_d    = en_eff;
      delay_d = (sys.sys_wen && addr == 20'h04) ? CW'(sys.sys_wdata)  : delay_q;
      width_d = (sys.sys_wen && addr == 20'h08) ? CW'(sys.sys_wdata)  : width_q;
      dead_d  = (sys.sys_wen && addr == 20'h0C) ? CW'(sys.sys_wdata)  : dead_q;
      amp_d   = (sys.sys_wen && addr == 20'h10) ? DWT'(sys.sys_wdata) : amp_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      width_s_d = width_s_q;
      dead_s_d  = dead_s_q;
      amp_s_d   = amp_s_q;
      evt_inc   = 1'b0;
      drop_inc  = 1'b0;
      if (!en_eff) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (evt) begin
                  evt_inc   = 1'b1;
                  width_s_d = width_q;
                  dead_s_d  = dead_q;
                  amp_s_d   = amp_q;
                  if (delay_q != '0) begin
                     state_d = DELAY;
                     cnt_d   = delay_q;
                  end else if (width_q != '0) begin
                     state_d = PULSE;
                     cnt_d   = width_q;
                  end else if (dead_q != '0) begin
                     state_d = DEAD;
                     cnt_d   = dead_q;
                  end
               end
            end
            DELAY: begin
               drop_inc = evt;
               if (cnt_q != ONE) begin
                  cnt_d = cnt_q - ONE;
               end else if (width_s_q != '0) begin
                  state_d = PULSE;
                  cnt_d   = width_s_q;
               end else if (dead_s_q != '0) begin
                  state_d = DEAD;
                  cnt_d   = dead_s_q;
               end else begin
                  state_d = IDLE;
               end
            end
            PULSE: begin
               drop_inc = evt;
               if (cnt_q != ONE) begin
                  cnt_d = cnt_q - ONE;
               end else if (dead_s_q != '0) begin
                  state_d = DEAD;
                  cnt_d   = dead_s_q;
               end else begin
                  state_d = IDLE;
               end
            end
            DEAD: begin
               drop_inc = evt;
               if (cnt_q != ONE) cnt_d = cnt_q - ONE;
               else              state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Counters saturate; a clear in the same cycle wins over an increment.
      evt_cnt_d  = evt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (clr_cnt) begin
         evt_cnt_d  = '0;
         drop_cnt_d = '0;
      end else begin
         if (evt_inc && evt_cnt_q != CNT_MAX)   evt_cnt_d  = evt_cnt_q + ONE;
         if (drop_inc && drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + ONE;
      end

      active_d = (state_d == PULSE);
      dac_d    = active_d ? amp_s_d : '0;
   end

   always_comb begin
      ack_d   = sys.sys_wen | sys.sys_ren;
      rdata_d = '0;
      if (sys.sys_ren) begin
         case (addr)
            20'h00:  rdata_d = {31'd0, en_q};
            20'h04:  rdata_d = 32'(delay_q);
            20'h08:  rdata_d = 32'(width_q);
            20'h0C:  rdata_d = 32'(dead_q);
            20'h10:  rdata_d = 32'(amp_q);
            20'h14:  rdata_d = 32'(evt_cnt_q);
            20'h18:  rdata_d = 32'(drop_cnt_q);
            20'h1C:  rdata_d = {30'd0, state_q};
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
      if (!adc_rstn_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         delay_q    <= '0;
         width_q    <= WIDTH_RST;
         dead_q     <= '0;
         amp_q      <= AMP_RST;
         width_s_q  <= '0;
         dead_s_q   <= '0;
         amp_s_q    <= '0;
         evt_cnt_q  <= '0;
         drop_cnt_q <= '0;
         dac_q      <= '0;
         en_q       <= 1'b0;
         trig_q     <= 1'b0;
         active_q   <= 1'b0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         delay_q    <= delay_d;
         width_q    <= width_d;
         dead_q     <= dead_d;
         amp_q      <= amp_d;
         width_s_q  <= width_s_d;
         dead_s_q   <= dead_s_d;
         amp_s_q    <= amp_s_d;
         evt_cnt_q  <= evt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         dac_q      <= dac_d;
         en_q       <= en_d;
         trig_q     <= trig_d;
         active_q   <= active_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
      end
   end

   assign dac_o          = dac_q;
   assign pulse_active_o = active_q;
   assign sys.sys_rdata  = rdata_q;
   assign sys.sys_ack    = ack_q;
   assign sys.sys_err    = 1'b0;

endmodule

// File: tb/tb_red_pitaya_sort_pulse.sv
// Directed bench for red_pitaya_sort_pulse: default build plus a CW=4 build
// for counter saturation. Inputs change 1 ns after posedge, outputs read there.
module tb_red_pitaya_sort_pulse;

   logic        clk = 1'b0;
   logic        rstn;
   logic        trig, trig4;
   logic [13:0] dac, dac4;
   logic        act, act4;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] rdata;
   logic        rack;
   logic        win;
   logic [13:0] exp_dac;
   int          act_cycles;

   always #5 clk = ~clk;

   red_pitaya_sort_pulse_if bus ();
   red_pitaya_sort_pulse_if bus4 ();

   red_pitaya_sort_pulse #(.DWT(14), .CW(32)) u_dut (
      .adc_clk_i      (clk),
      .adc_rstn_i     (rstn),
      .sort_trig_i    (trig),
      .dac_o          (dac),
      .pulse_active_o (act),
      .sys            (bus)
   );

   red_pitaya_sort_pulse #(.DWT(14), .CW(4)) u_dut4 (
      .adc_clk_i      (clk),
      .adc_rstn_i     (rstn),
      .sort_trig_i    (trig4),
      .dac_o          (dac4),
      .pulse_active_o (act4),
      .sys            (bus4)
   );

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [19:0] a, input logic [31:0] d);
      bus.sys_addr  = {12'h0, a};
      bus.sys_wdata = d;
      bus.sys_wen   = 1'b1;
      step();
      bus.sys_wen   = 1'b0;
   endtask

   task automatic rd(input logic [19:0] a, output logic [31:0] d, output logic ack);
      bus.sys_addr = {12'h0, a};
      bus.sys_ren  = 1'b1;
      step();
      d            = bus.sys_rdata;
      ack          = bus.sys_ack;
      bus.sys_ren  = 1'b0;
   endtask

   task automatic wr4(input logic [19:0] a, input logic [31:0] d);
      bus4.sys_addr  = {12'h0, a};
      bus4.sys_wdata = d;
      bus4.sys_wen   = 1'b1;
      step();
      bus4.sys_wen   = 1'b0;
   endtask

   task automatic rd4(input logic [19:0] a, output logic [31:0] d);
      bus4.sys_addr = {12'h0, a};
      bus4.sys_ren  = 1'b1;
      step();
      d             = bus4.sys_rdata;
      bus4.sys_ren  = 1'b0;
   endtask

   // Disable (forces IDLE), program timing/amp, then enable with counters cleared.
   task automatic cfg(input logic [31:0] dly, input logic [31:0] wid,
                      input logic [31:0] dd, input logic [31:0] amp);
      wr(20'h00, 32'd0);
      wr(20'h04, dly);
      wr(20'h08, wid);
      wr(20'h0C, dd);
      wr(20'h10, amp);
      wr(20'h00, 32'd5);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 1'b0;
      step();
      step();
      checks++;
      if ({act, dac, bus.sys_ack, bus.sys_rdata} !== 48'd0) begin
         errors++;
         $display("FAIL reset_outputs act=%b dac=%h ack=%b rdata=%h want all 0",
                  act, dac, bus.sys_ack, bus.sys_rdata);
      end
      rstn = 1'b1;
      step();
      bus.sys_addr = 32'h8;
      bus.sys_ren  = 1'b1;
      #2;
      checks++;
      if (bus.sys_ack !== 1'b0) begin
         errors++;
         $display("FAIL ack_early got %b want 0", bus.sys_ack);
      end
      step();
      checks++;
      if (bus.sys_ack !== 1'b1 || bus.sys_rdata !== 32'd1250) begin
         errors++;
         $display("FAIL width_default ack=%b rdata=%0d want ack=1 rdata=1250",
                  bus.sys_ack, bus.sys_rdata);
      end
      bus.sys_ren = 1'b0;
      step();
      checks++;
      if (bus.sys_ack !== 1'b0) begin
         errors++;
         $display("FAIL ack_drop got %b want 0", bus.sys_ack);
      end
      rd(20'h10, rdata, rack);
      checks++;
      if (rdata !== 32'h1FFF) begin
         errors++;
         $display("FAIL amp_default got %h want 1fff", rdata);
      end
      rd(20'h20, rdata, rack);
      checks++;
      if (rdata !== 32'd0 || rack !== 1'b1) begin
         errors++;
         $display("FAIL unmapped got %h ack=%b want 0 ack=1", rdata, rack);
      end
      rd(20'h1C, rdata, rack);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL status_reset got %0d want 0", rdata);
      end
   endtask

   task automatic test_basic_pulse();
      cfg(32'd10, 32'd5, 32'd0, 32'h1000);
      for (int k = 0; k < 20; k++) begin
         trig = (k == 0);
         step();
         win     = (k >= 10 && k <= 14);
         exp_dac = win ? 14'h1000 : 14'h0;
         checks++;
         if ({act, dac} !== {win, exp_dac}) begin
            errors++;
            $display("FAIL basic_pulse j=%0d act=%b dac=%h want act=%b dac=%h",
                     k, act, dac, win, exp_dac);
         end
      end
      trig = 1'b0;
      rd(20'h14, rdata, rack);
      checks++;
      if (rdata !== 32'd1) begin
         errors++;
         $display("FAIL basic_evt_cnt got %0d want 1", rdata);
      end
   endtask

   task automatic test_dead_drop();
      cfg(32'd10, 32'd5, 32'd20, 32'h1000);
      for (int k = 0; k <= 60; k++) begin
         trig = (k == 0 || k == 8 || k == 40);
         step();
         win     = (k >= 10 && k <= 14) || (k >= 50 && k <= 54);
         exp_dac = win ? 14'h1000 : 14'h0;
         checks++;
         if ({act, dac} !== {win, exp_dac}) begin
            errors++;
            $display("FAIL dead_pulse j=%0d act=%b dac=%h want act=%b dac=%h",
                     k, act, dac, win, exp_dac);
         end
      end
      trig = 1'b0;
      rd(20'h14, rdata, rack);
      checks++;
      if (rdata !== 32'd2) begin
         errors++;
         $display("FAIL dead_evt_cnt got %0d want 2", rdata);
      end
      rd(20'h18, rdata, rack);
      checks++;
      if (rdata !== 32'd1) begin
         errors++;
         $display("FAIL dead_drop_cnt got %0d want 1", rdata);
      end
      rd(20'h1C, rdata, rack);
      checks++;
      if (rdata !== 32'd3) begin
         errors++;
         $display("FAIL status_dead got %0d want 3", rdata);
      end
      repeat (15) step();
      rd(20'h1C, rdata, rack);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL status_idle got %0d want 0", rdata);
      end
   endtask

   task automatic test_level_and_sw_trig();
      cfg(32'd2, 32'd3, 32'd0, 32'h0555);
      act_cycles = 0;
      trig = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step();
         if (act) act_cycles++;
      end
      trig = 1'b0;
      step();
      checks++;
      if (act_cycles != 3) begin
         errors++;
         $display("FAIL level_pulse_len got %0d want 3", act_cycles);
      end
      rd(20'h14, rdata, rack);
      checks++;
      if (rdata !== 32'd1) begin
         errors++;
         $display("FAIL level_evt_cnt got %0d want 1", rdata);
      end
      // sw_trig write landing on the same edge as a rising sort_trig
      cfg(32'd2, 32'd3, 32'd0, 32'h0AAA);
      bus.sys_addr  = 32'h0;
      bus.sys_wdata = 32'd3;
      bus.sys_wen   = 1'b1;
      trig          = 1'b1;
      step();
      bus.sys_wen = 1'b0;
      trig        = 1'b0;
      for (int k = 1; k < 8; k++) begin
         step();
         win     = (k >= 2 && k <= 4);
         exp_dac = win ? 14'h0AAA : 14'h0;
         checks++;
         if ({act, dac} !== {win, exp_dac}) begin
            errors++;
            $display("FAIL coincide_pulse j=%0d act=%b dac=%h want act=%b dac=%h",
                     k, act, dac, win, exp_dac);
         end
      end
      rd(20'h14, rdata, rack);
      checks++;
      if (rdata !== 32'd1) begin
         errors++;
         $display("FAIL coincide_evt_cnt got %0d want 1", rdata);
      end
      rd(20'h18, rdata, rack);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL coincide_drop_cnt got %0d want 0", rdata);
      end
      wr(20'h00, 32'd3);
      for (int k = 1; k < 8; k++) begin
         step();
         win     = (k >= 2 && k <= 4);
         exp_dac = win ? 14'h0AAA : 14'h0;
         checks++;
         if ({act, dac} !== {win, exp_dac}) begin
            errors++;
            $display("FAIL sw_pulse j=%0d act=%b dac=%h want act=%b dac=%h",
                     k, act, dac, win, exp_dac);
         end
      end
      rd(20'h14, rdata, rack);
      checks++;
      if (rdata !== 32'd2) begin
         errors++;
         $display("FAIL sw_evt_cnt got %0d want 2", rdata);
      end
   endtask

   task automatic test_zero_width();
      cfg(32'd0, 32'd0, 32'd0, 32'h2000);
      for (int k = 0; k < 10; k++) begin
         trig = (k == 0);
         step();
         checks++;
         if ({act, dac} !== 15'd0) begin
            errors++;
            $display("FAIL zero_width j=%0d act=%b dac=%h want 0", k, act, dac);
         end
      end
      trig = 1'b0;
      rd(20'h14, rdata, rack);
      checks++;
      if (rdata !== 32'd1) begin
         errors++;
         $display("FAIL zero_width_evt got %0d want 1", rdata);
      end
      wr(20'h08, 32'd1);
      for (int k = 0; k < 5; k++) begin
         trig = (k == 0);
         step();
         win     = (k == 0);
         exp_dac = win ? 14'h2000 : 14'h0;
         checks++;
         if ({act, dac} !== {win, exp_dac}) begin
            errors++;
            $display("FAIL width1_neg j=%0d act=%b dac=%h want act=%b dac=%h",
                     k, act, dac, win, exp_dac);
         end
      end
      trig = 1'b0;
   endtask

   task automatic test_mid_write();
      cfg(32'd10, 32'd5, 32'd0, 32'h1000);
      for (int k = 0; k < 20; k++) begin
         trig          = (k == 0);
         bus.sys_addr  = 32'h8;
         bus.sys_wdata = 32'd3;
         bus.sys_wen   = (k == 2);
         step();
         win     = (k >= 10 && k <= 14);
         exp_dac = win ? 14'h1000 : 14'h0;
         checks++;
         if ({act, dac} !== {win, exp_dac}) begin
            errors++;
            $display("FAIL mid_write_cur j=%0d act=%b dac=%h want act=%b dac=%h",
                     k, act, dac, win, exp_dac);
         end
      end
      bus.sys_wen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         trig = (k == 0);
         step();
         win     = (k >= 10 && k <= 12);
         exp_dac = win ? 14'h1000 : 14'h0;
         checks++;
         if ({act, dac} !== {win, exp_dac}) begin
            errors++;
            $display("FAIL mid_write_next j=%0d act=%b dac=%h want act=%b dac=%h",
                     k, act, dac, win, exp_dac);
         end
      end
      trig = 1'b0;
   endtask

   task automatic test_disable();
      cfg(32'd2, 32'd10, 32'd5, 32'h1234);
      for (int k = 0; k < 13; k++) begin
         trig          = (k == 0);
         bus.sys_addr  = 32'h0;
         bus.sys_wdata = 32'd0;
         bus.sys_wen   = (k == 5);
         step();
         win     = (k >= 2 && k <= 4);
         exp_dac = win ? 14'h1234 : 14'h0;
         checks++;
         if ({act, dac} !== {win, exp_dac}) begin
            errors++;
            $display("FAIL disable j=%0d act=%b dac=%h want act=%b dac=%h",
                     k, act, dac, win, exp_dac);
         end
      end
      bus.sys_wen = 1'b0;
      trig        = 1'b0;
      rd(20'h1C, rdata, rack);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL disable_status got %0d want 0", rdata);
      end
      rd(20'h18, rdata, rack);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL disable_drop got %0d want 0", rdata);
      end
   endtask

   task automatic test_saturation();
      wr4(20'h04, 32'd15);
      wr4(20'h08, 32'd15);
      wr4(20'h0C, 32'd15);
      wr4(20'h00, 32'd1);
      for (int k = 0; k < 40; k++) begin
         trig4 = (k % 2 == 0);
         step();
      end
      trig4 = 1'b0;
      rd4(20'h18, rdata);
      checks++;
      if (rdata !== 32'd15) begin
         errors++;
         $display("FAIL drop_saturate got %0d want 15", rdata);
      end
      rd4(20'h14, rdata);
      checks++;
      if (rdata !== 32'd1) begin
         errors++;
         $display("FAIL sat_evt_cnt got %0d want 1", rdata);
      end
      wr4(20'h00, 32'd5);
      rd4(20'h18, rdata);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL clr_drop got %0d want 0", rdata);
      end
      rd4(20'h14, rdata);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL clr_evt got %0d want 0", rdata);
      end
   endtask

   task automatic test_async_reset();
      cfg(32'd0, 32'd20, 32'd0, 32'h0123);
      for (int k = 0; k < 4; k++) begin
         trig = (k == 0);
         step();
      end
      trig = 1'b0;
      checks++;
      if ({act, dac} !== {1'b1, 14'h0123}) begin
         errors++;
         $display("FAIL pre_reset_pulse act=%b dac=%h want act=1 dac=0123", act, dac);
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({act, dac} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset act=%b dac=%h want 0", act, dac);
      end
      step();
      rstn = 1'b1;
      step();
      rd(20'h08, rdata, rack);
      checks++;
      if (rdata !== 32'd1250) begin
         errors++;
         $display("FAIL post_reset_width got %0d want 1250", rdata);
      end
      rd(20'h10, rdata, rack);
      checks++;
      if (rdata !== 32'h1FFF) begin
         errors++;
         $display("FAIL post_reset_amp got %h want 1fff", rdata);
      end
      rd(20'h00, rdata, rack);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL post_reset_ctrl got %0d want 0", rdata);
      end
      rd(20'h14, rdata, rack);
      checks++;
      if (rdata !== 32'd0) begin
         errors++;
         $display("FAIL post_reset_evt got %0d want 0", rdata);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rstn           = 1'b0;
      trig           = 1'b0;
      trig4          = 1'b0;
      bus.sys_addr   = '0;
      bus.sys_wdata  = '0;
      bus.sys_sel    = 4'hF;
      bus.sys_wen    = 1'b0;
      bus.sys_ren    = 1'b0;
      bus4.sys_addr  = '0;
      bus4.sys_wdata = '0;
      bus4.sys_sel   = 4'hF;
      bus4.sys_wen   = 1'b0;
      bus4.sys_ren   = 1'b0;

      test_reset();
      test_basic_pulse();
      test_dead_drop();
      test_level_and_sw_trig();
      test_zero_width();
      test_mid_write();
      test_disable();
      test_saturation();
      test_async_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
